delay_timer_arbiter: RTL and testbench
======================================

DELAY_TIMER_ARBITER -- requirements
Module: delay_timer_arbiter

Interface
REQ-001 Parameter PRESCALE, default 50_000: clk_in cycles per timer tick (1 ms at 50 MHz); legal range 2 to 2^20.
REQ-002 Parameter CW, default 16: width of each requester's delay field, in ticks.
REQ-003 clk_in  input  1  single system clock; all logic is on its rising edge.
REQ-004 nReset  input  1  reset, synchronous and active-low: sampled only on the clk_in rising edge.
REQ-005 req  input  4  per-requester delay request; bit i belongs to requester i.
REQ-006 dly_in  input  4*CW  packed delays; bits [i*CW +: CW] give requester i's delay in ticks.
REQ-007 gnt  output  4  one-hot grant; bit i high while requester i owns the timer.
REQ-008 done  output  4  one-cycle pulse on bit i when requester i's delay expires.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 tick  output  1  one-cycle prescaler strobe, active only in RUN.

Function
REQ-011 The block shall implement four states: IDLE, RUN, DONE and ABORT.
REQ-012 IDLE: if req is nonzero in cycle T, the block shall pick a winner by round-robin, starting at the index after last_winner and wrapping 3->0.
- In cycle T+1: gnt shall be one-hot on the winner; the block shall latch the winner's dly_in (sampled in cycle T) into cnt and enter RUN.
REQ-013 RUN: the prescaler shall start at 0 on entry and count 0..PRESCALE-1.
- tick shall assert in the cycle where the prescaler equals PRESCALE-1; the prescaler shall then wrap to 0.
- cnt shall decrement by 1 on each tick.
REQ-014 If the grant rises in cycle G with latched delay D>=1, the block shall enter DONE in cycle G+D*PRESCALE.
- In DONE: done[winner]=1, gnt=0, busy=1.
- last_winner shall be updated to the winner.
- The block shall return to IDLE in the next cycle.
REQ-015 D=0: the block shall enter DONE in cycle G+1 with no tick.
REQ-016 Changes to dly_in after the latch cycle shall have no effect on the running delay.
REQ-017 A requester still asserting req in the DONE cycle shall be treated as a new request in IDLE.
- Because of round-robin order, other pending requesters shall be served first.
REQ-018 Requests arriving while the block is busy shall wait; none shall be dropped while req stays high.
REQ-019 Outputs shall be registered.
- gnt shall be zero or one-hot in every cycle.
- At most one done bit shall be high per cycle.
- A done bit and its gnt bit shall never be high together.
REQ-020 Minimum spacing between successive grants shall be 2 cycles (DONE, then IDLE).

Reset
REQ-021 When nReset=0 at a clk_in edge: state=IDLE, gnt=0, done=0, busy=0, tick=0, cnt=0, prescaler=0, last_winner=3 (so requester 0 wins first).
REQ-022 Reset asserted during RUN shall abandon the delay without a done pulse; outputs shall take reset values at that edge.
REQ-023 Reset shall override every simultaneous event, including an expiring tick.

Configuration
REQ-024 Macro TIMER_ARB_ABORT_EN.
- Defined: if req[winner] is 0 in any RUN cycle, the block shall enter ABORT in the next cycle.
  - In ABORT: gnt=0, done=0, busy=1; last_winner shall be updated; the block shall then go to IDLE.
  - If req drops in the same cycle as the final tick, ABORT shall take priority and no done pulse shall occur.
- Undefined: req[winner] shall be ignored during RUN, and the delay shall always run to DONE; the ABORT state shall not exist.

Verification (PRESCALE=4, CW=8)
REQ-025 Single request: req=0001, delay 3, in cycle 0 -> gnt=0001 in cycle 1, tick in cycles 4, 8, 12, done=0001 in cycle 13, busy low in cycle 14.
REQ-026 Contention: req=1111 held throughout, all delays 1 -> grant order 0, 1, 2, 3, 0; each gnt-rise to next gnt-rise is 6 cycles.
REQ-027 Zero delay: req=0100, delay 0 -> gnt=0100 for one cycle, done=0100 in the next cycle, no tick.
REQ-028 Abort (macro defined): req0 dropped in cycle 5 of a delay-3 run -> gnt=0 in cycle 6, no done, requester 1 granted next if pending; with the macro undefined, done still pulses in cycle 13.
REQ-029 Reset mid-run: nReset=0 in cycle 7 of a delay-3 run -> all outputs 0 at that edge, no done pulse; after release with req=0001, gnt=0001 one cycle later.

Source files
------------

// File: rtl/delay_timer_arbiter.sv
// delay_timer_arbiter
//   Four requesters share one prescaled delay timer. A round-robin arbiter
//   picks one pending requester, latches its delay (in ticks of PRESCALE
//   clk_in cycles), runs the countdown and pulses done for that requester.
//
// Parameters
//   PRESCALE  clk_in cycles per tick (2 .. 2^20)
//   CW        width of each requester's delay field
// Ports
//   clk_in    system clock, rising edge
//   nReset    synchronous active-low reset
//   req[3:0]  per-requester delay request
//   dly_in    packed delays, requester i at [i*CW +: CW]
//   gnt[3:0]  one-hot grant while a requester owns the timer
//   done[3:0] one-cycle expiry pulse for the owning requester
//   busy      high whenever the block is not idle
//   tick      one-cycle prescaler strobe while running
// Configuration
//   TIMER_ARB_ABORT_EN  when defined, dropping req of the owner during the
//                       countdown aborts it (no done pulse).
module delay_timer_arbiter #(
  parameter int unsigned PRESCALE = 50_000,
  parameter int unsigned CW       = 16
) (
  input  logic            clk_in,
  input  logic            nReset,
  input  logic [3:0]      req,
  input  logic [4*CW-1:0] dly_in,
  output logic [3:0]      gnt,
  output logic [3:0]      done,
  output logic            busy,
  output logic            tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

`ifdef TIMER_ARB_ABORT_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ABORT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

  state_t          state_q, state_d;
  logic [1:0]      winner_q, winner_d;
  logic [1:0]      last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [3:0]      done_q, done_d;
  logic            busy_q, busy_d;
  logic            tick_q, tick_d;

  logic            rr_found;
  logic [1:0]      rr_idx;
  logic [1:0]      rr_cand;
  logic            tick_fire;

  // Round-robin search: offsets 1..4 from the last winner; offset 4 wraps
  // back onto the last winner itself, so it is considered last.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = last_q;
    rr_cand  = last_q;
    for (int unsigned off = 1; off <= 4; off++) begin
      rr_cand = last_q + 2'(off);
      if (!rr_found && req[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  assign tick_fire = (state_q == S_RUN) && (presc_q == PRESC_MAX);

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    presc_d  = '0;

    case (state_q)
      S_IDLE: begin
        if (rr_found) begin
          winner_d = rr_idx;
          cnt_d    = dly_in[rr_idx*CW +: CW];
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        presc_d = tick_fire ? '0 : presc_q + 1'b1;
        if (tick_fire) begin
          cnt_d = cnt_q - 1'b1;
        end
        // A zero delay expires on the first RUN cycle; otherwise expiry is
        // the tick that takes the count from 1 to 0.
        if ((cnt_q == '0) || (tick_fire && (cnt_q == CW'(1)))) begin
          state_d = S_DONE;
          presc_d = '0;
        end
`ifdef TIMER_ARB_ABORT_EN
        // Abort wins over a simultaneous expiry.
        if (!req[winner_q]) begin
          state_d = S_ABORT;
          presc_d = '0;
        end
`endif
      end
      S_DONE: begin
        last_d  = winner_q;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
`ifdef TIMER_ARB_ABORT_EN
      S_ABORT: begin
        last_d  = winner_q;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they come straight off flops.
  always_comb begin
    gnt_d  = (state_d == S_RUN)  ? (4'b0001 << winner_d) : '0;
    done_d = (state_d == S_DONE) ? (4'b0001 << winner_d) : '0;
    busy_d = (state_d != S_IDLE);
    tick_d = (state_d == S_RUN) && (presc_d == PRESC_MAX);
  end

  always_ff @(posedge clk_in) begin
    if (!nReset) begin
      state_q  <= S_IDLE;
      winner_q <= '0;
      last_q   <= 2'd3;
      cnt_q    <= '0;
      presc_q  <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      presc_q  <= presc_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      tick_q   <= tick_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = busy_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Testbench for delay_timer_arbiter (PRESCALE=4, CW=8). A time-based
// reference model predicts each cycle's outputs from the grant cycle and
// the computed expiry cycle; directed scenarios are followed by random
// request/delay/reset traffic.
module tb_delay_timer_arbiter;

  localparam int P  = 4;
  localparam int CW = 8;

  logic          clk_in = 1'b0;
  logic          nReset;
  logic [3:0]    req;
  logic [4*CW-1:0] dly_in;
  logic [3:0]    gnt, done;
  logic          busy, tick;

  delay_timer_arbiter #(.PRESCALE(P), .CW(CW)) dut (
    .clk_in (clk_in),
    .nReset (nReset),
    .req    (req),
    .dly_in (dly_in),
    .gnt    (gnt),
    .done   (done),
    .busy   (busy),
    .tick   (tick)
  );

  always #5 clk_in = ~clk_in;

  int ncmp  = 0;
  int nfail = 0;
  int cyc   = 0;

  // Reference model: owner index (-1 when idle), grant cycle, expiry cycle.
  int  m_owner = -1;
  int  m_g     = 0;
  int  m_end   = 0;
  int  m_last  = 3;
  bit  m_abort = 0;
  logic [3:0] e_gnt, e_done;
  logic       e_busy, e_tick;

  // Directed-scenario trackers.
  int  rise_cyc, done_cyc, tick_cnt;
  logic [3:0] prev_gnt = '0;
  int  rise_list[$];

  // Predict outputs of cycle c+1 from inputs present in cycle c.
  task automatic predict(input int c);
    int w, d;
    e_gnt = '0; e_done = '0; e_busy = 1'b0; e_tick = 1'b0;
    if (!nReset) begin
      m_owner = -1;
      m_last  = 3;
      return;
    end
    if (m_owner < 0) begin
      if (req != 4'b0000) begin
        w = -1;
        for (int i = 1; i <= 4; i++)
          if (w < 0 && req[(m_last + i) % 4]) w = (m_last + i) % 4;
        d       = int'(dly_in[w*CW +: CW]);
        m_owner = w;
        m_g     = c + 1;
        m_end   = m_g + ((d == 0) ? 1 : d * P);
        m_abort = 0;
        e_gnt   = 4'b0001 << w;
        e_busy  = 1'b1;
      end
    end else if (c == m_end) begin
      m_owner = -1;
    end else begin
`ifdef TIMER_ARB_ABORT_EN
      if (!req[m_owner]) begin
        m_abort = 1;
        m_end   = c + 1;
      end
`endif
      if (c + 1 == m_end) begin
        e_busy = 1'b1;
        if (!m_abort) e_done = 4'b0001 << m_owner;
        m_last = m_owner;
      end else begin
        e_gnt  = 4'b0001 << m_owner;
        e_busy = 1'b1;
        e_tick = (((c + 1 - m_g) % P) == P - 1);
      end
    end
  endtask

  task automatic step();
    predict(cyc);
    @(posedge clk_in);
    #1;
    cyc++;
    ncmp++;
    assert (gnt === e_gnt) else begin
      nfail++; $error("FAIL gnt cyc=%0d observed=%b expected=%b", cyc, gnt, e_gnt);
    end
    ncmp++;
    assert (done === e_done) else begin
      nfail++; $error("FAIL done cyc=%0d observed=%b expected=%b", cyc, done, e_done);
    end
    ncmp++;
    assert (busy === e_busy) else begin
      nfail++; $error("FAIL busy cyc=%0d observed=%b expected=%b", cyc, busy, e_busy);
    end
    ncmp++;
    assert (tick === e_tick) else begin
      nfail++; $error("FAIL tick cyc=%0d observed=%b expected=%b", cyc, tick, e_tick);
    end
    ncmp++;
    assert ($onehot0(gnt) && $onehot0(done) && ((gnt & done) == 4'b0000)) else begin
      nfail++; $error("FAIL onehot cyc=%0d observed gnt=%b done=%b expected disjoint one-hot", cyc, gnt, done);
    end
    if (gnt != 4'b0000 && prev_gnt == 4'b0000) begin
      rise_cyc = cyc;
      rise_list.push_back(cyc);
    end
    if (done != 4'b0000) done_cyc = cyc;
    if (tick) tick_cnt++;
    prev_gnt = gnt;
  endtask

  task automatic settle();
    req = '0;
    for (int i = 0; i < 40; i++) step();
  endtask

  task automatic set_dly(input int idx, input int v);
    dly_in[idx*CW +: CW] = CW'(v);
  endtask

  initial begin
    nReset = 1'b0;
    req    = '0;
    dly_in = '0;
    for (int i = 0; i < 3; i++) step();
    nReset = 1'b1;
    step();

    // Single request, delay 3: done lands 12 cycles after the grant rise.
    set_dly(0, 3);
    req = 4'b0001;
    rise_cyc = -1; done_cyc = -1; tick_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done != 4'b0000) req = '0;
      set_dly(0, $urandom_range(0, 255));
    end
    ncmp++;
    assert (done_cyc - rise_cyc === 12) else begin
      nfail++; $error("FAIL single_latency observed=%0d expected=%0d", done_cyc - rise_cyc, 12);
    end
    ncmp++;
    assert (tick_cnt === 3) else begin
      nfail++; $error("FAIL single_ticks observed=%0d expected=%0d", tick_cnt, 3);
    end
    settle();

    // Contention: all four held, delay 1 each; rises every 6 cycles.
    for (int i = 0; i < 4; i++) set_dly(i, 1);
    rise_list.delete();
    req = 4'b1111;
    for (int i = 0; i < 32; i++) step();
    ncmp++;
    assert (rise_list.size() >= 5 && rise_list[1] - rise_list[0] === 6 &&
            rise_list[4] - rise_list[3] === 6) else begin
      nfail++; $error("FAIL contention_spacing observed=%0d rises expected=6-cycle spacing", rise_list.size());
    end
    settle();

    // Zero delay on requester 2.
    set_dly(2, 0);
    req = 4'b0100;
    tick_cnt = 0;
    for (int i = 0; i < 3; i++) step();
    req = '0;
    for (int i = 0; i < 4; i++) step();
    ncmp++;
    assert (tick_cnt === 0) else begin
      nfail++; $error("FAIL zero_delay_tick observed=%0d expected=%0d", tick_cnt, 0);
    end
    settle();

    // Owner 0 drops req mid-run while requester 1 is pending.
    set_dly(0, 3);
    set_dly(1, 2);
    req = 4'b0011;
    for (int i = 0; i < 5; i++) step();
    req = 4'b0010;
    for (int i = 0; i < 30; i++) step();
    settle();

    // Reset mid-run, then a fresh request after release.
    set_dly(0, 3);
    req = 4'b0001;
    for (int i = 0; i < 7; i++) step();
    nReset = 1'b0;
    step();
    nReset = 1'b1;
    req = 4'b0001;
    step();
    step();
    settle();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 7) == 0) req[i] = 1'b1;
        end else if ($urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
        set_dly(i, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 2));
      end
      nReset = ($urandom_range(0, 299) != 0);
      step();
    end
    nReset = 1'b1;
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
